// File: rtl/dds_sweep_scheduler.sv
// Linear frequency-sweep sequencer for the DDS phase increment.
// Steps are applied only on DDS zero crossings after a programmable dwell.
module dds_sweep_scheduler #(
  parameter int INC_WIDTH = 32,
  parameter int DWELL_WIDTH = 16,
  parameter logic [INC_WIDTH-1:0] RESET_INC = 32'h00760A84
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [1:0]             i_mode,
  input  logic [INC_WIDTH-1:0]   i_inc_start,
  input  logic [INC_WIDTH-1:0]   i_inc_stop,
  input  logic [INC_WIDTH-1:0]   i_inc_step,
  input  logic [DWELL_WIDTH-1:0] i_dwell,
  input  logic                   i_zero_crossing,
  output logic [INC_WIDTH-1:0]   o_incremento,
  output logic                   o_dds_rst,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [2:0]             o_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_DWELL   = 3'd2,
    S_WAIT_ZC = 3'd3,
    S_STEP    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [1:0] MODE_SAW = 2'b01;
  localparam logic [1:0] MODE_TRI = 2'b10;
  localparam logic [DWELL_WIDTH-1:0] DWELL_ONE = DWELL_WIDTH'(1);

  state_t                 state_reg;
  logic [1:0]             mode_reg;
  logic [INC_WIDTH-1:0]   start_reg, stop_reg, step_reg, inc_reg;
  logic [DWELL_WIDTH-1:0] dwell_reg, cnt_reg;
  logic                   dir_up_reg, dds_rst_reg, done_reg, err_reg;

  logic [INC_WIDTH:0]     sum_up, diff_dn;
  logic [INC_WIDTH-1:0]   inc_next;
  logic                   last_point;

  // One extra bit so overflow (up) and underflow (down) clamp instead of wrapping.
  always_comb begin
    sum_up  = {1'b0, inc_reg} + {1'b0, step_reg};
    diff_dn = {1'b0, inc_reg} - {1'b0, step_reg};
    inc_next = inc_reg;
    if (dir_up_reg) begin
      if (sum_up >= {1'b0, stop_reg}) inc_next = stop_reg;
      else                            inc_next = sum_up[INC_WIDTH-1:0];
    end else begin
      if (diff_dn[INC_WIDTH] || (diff_dn[INC_WIDTH-1:0] < start_reg)) inc_next = start_reg;
      else                                                             inc_next = diff_dn[INC_WIDTH-1:0];
    end
    last_point = dir_up_reg ? (inc_reg == stop_reg) : (inc_reg == start_reg);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= S_IDLE;
      mode_reg    <= '0;
      start_reg   <= '0;
      stop_reg    <= '0;
      step_reg    <= '0;
      dwell_reg   <= DWELL_ONE;
      cnt_reg     <= '0;
      inc_reg     <= RESET_INC;
      dir_up_reg  <= 1'b1;
      dds_rst_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      dds_rst_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      if (i_abort && state_reg != S_IDLE) begin
        state_reg <= S_IDLE;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (i_start && !i_abort) begin
              mode_reg  <= i_mode;
              start_reg <= i_inc_start;
              stop_reg  <= i_inc_stop;
              step_reg  <= i_inc_step;
              dwell_reg <= (i_dwell == '0) ? DWELL_ONE : i_dwell;
              if (i_inc_step == '0 || i_inc_start > i_inc_stop) begin
                err_reg <= 1'b1;
              end else begin
                state_reg   <= S_LOAD;
                dds_rst_reg <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            inc_reg    <= start_reg;
            dir_up_reg <= 1'b1;
            cnt_reg    <= dwell_reg;
            state_reg  <= S_DWELL;
          end
          S_DWELL: begin
            if (cnt_reg <= DWELL_ONE) state_reg <= S_WAIT_ZC;
            else                      cnt_reg   <= cnt_reg - DWELL_ONE;
          end
          S_WAIT_ZC: begin
            if (i_zero_crossing) begin
              if (!last_point) begin
                state_reg <= S_STEP;
              end else if (mode_reg == MODE_SAW) begin
                inc_reg   <= start_reg;
                cnt_reg   <= dwell_reg;
                state_reg <= S_DWELL;
              end else if (mode_reg == MODE_TRI) begin
                dir_up_reg <= ~dir_up_reg;
                state_reg  <= S_STEP;
              end else begin
                done_reg  <= 1'b1;
                state_reg <= S_DONE;
              end
            end
          end
          S_STEP: begin
            inc_reg   <= inc_next;
            cnt_reg   <= dwell_reg;
            state_reg <= S_DWELL;
          end
          S_DONE:  state_reg <= S_IDLE;
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  assign o_incremento = inc_reg;
  assign o_dds_rst    = dds_rst_reg;
  assign o_done       = done_reg;
  assign o_err        = err_reg;
  assign o_busy       = (state_reg != S_IDLE);
  assign o_state      = state_reg;

endmodule
